// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH divided waveforms/ticks from one clock, DRP-style per-channel config, lock sequencer.
// Optional feature: define CLKDIV_READBACK_EN to return stored channel settings on cfg_do.

module clk_div_lane #(
   parameter int DIV_W       = 8,
   parameter int DIV_DEFAULT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [3*DIV_W-1:0] wr_data,
   input  logic               load,
   input  logic               run,
   output logic               clk_out,
   output logic               tick
`ifdef CLKDIV_READBACK_EN
   ,
   output logic [3*DIV_W-1:0] cfg_raw
`endif
);

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DIV_DEFAULT);
   localparam logic [DIV_W-1:0] DEF_HI  = DIV_W'(DIV_DEFAULT / 2);
   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

   logic [DIV_W-1:0] div_q, div_d, hi_q, hi_d, ph_q, ph_d, cnt_q, cnt_d;
   logic [DIV_W-1:0] d_eff, d_m1, h_eff, p_eff;
   logic             clk_out_q, clk_out_d, tick_q, tick_d;

   // Raw fields are stored as written; clamping happens only here.
   always_comb begin
      d_eff = (div_q < TWO) ? TWO : div_q;
      d_m1  = d_eff - ONE;
      h_eff = (hi_q == '0) ? ONE : ((hi_q > d_m1) ? d_m1 : hi_q);
      p_eff = (ph_q < d_eff) ? ph_q : '0;
   end

   always_comb begin
      {ph_d, hi_d, div_d} = wr_en ? wr_data : {ph_q, hi_q, div_q};
      if (load)
         cnt_d = p_eff;
      else if (cnt_q >= d_m1)
         cnt_d = '0;
      else
         cnt_d = cnt_q + ONE;
      clk_out_d = run && (cnt_q < h_eff);
      tick_d    = run && (cnt_q == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q     <= DEF_DIV;
         hi_q      <= DEF_HI;
         ph_q      <= '0;
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         div_q     <= div_d;
         hi_q      <= hi_d;
         ph_q      <= ph_d;
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign clk_out = clk_out_q;
   assign tick    = tick_q;
`ifdef CLKDIV_READBACK_EN
   assign cfg_raw = {ph_q, hi_q, div_q};
`endif

endmodule

module clk_div_bank #(
   parameter int NUM_CH      = 6,
   parameter int DIV_W       = 8,
   parameter int ADDR_W      = 4,
   parameter int DIV_DEFAULT = 2,
   parameter int LOCK_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pwrdwn,
   input  logic                cfg_en,
   input  logic                cfg_we,
   input  logic [ADDR_W-1:0]   cfg_addr,
   input  logic [3*DIV_W-1:0]  cfg_di,
   output logic [3*DIV_W-1:0]  cfg_do,
   output logic                cfg_rdy,
   output logic [NUM_CH-1:0]   clk_out,
   output logic [NUM_CH-1:0]   tick,
   output logic                locked
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ALIGN  = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_LOCKED = 2'd3;
   localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   logic [1:0]        state_q, state_d;
   logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
   logic              locked_q, locked_d;
   logic              cfg_rdy_q, cfg_rdy_d;
   logic              addr_ok, wr_acc, load, run;
   logic [NUM_CH-1:0] lane_wr;

   assign addr_ok = 32'(cfg_addr) < 32'(NUM_CH);
   assign wr_acc  = cfg_en && cfg_we && addr_ok;

   always_comb begin
      lane_wr = '0;
      for (int i = 0; i < NUM_CH; i++)
         lane_wr[i] = wr_acc && (cfg_addr == ADDR_W'(i));
   end

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         ST_IDLE:  state_d = ST_ALIGN;
         ST_ALIGN: begin
            state_d    = ST_WAIT;
            lock_cnt_d = '0;
         end
         ST_WAIT: begin
            if (lock_cnt_q == LCW'(LOCK_CYCLES - 1))
               state_d = ST_LOCKED;
            else
               lock_cnt_d = lock_cnt_q + LCW'(1);
         end
         default:  state_d = ST_LOCKED;
      endcase
      // A retuned channel forces a full realign so every channel stays phase-related.
      if (pwrdwn)
         state_d = ST_IDLE;
      else if (wr_acc && (state_q != ST_IDLE))
         state_d = ST_ALIGN;
      locked_d  = (state_d == ST_LOCKED);
      cfg_rdy_d = cfg_en;
   end

   // Outputs only run while both this and the next state are WAIT/LOCKED, so they drop on the same edge.
   assign load = (state_q == ST_ALIGN);
   assign run  = ((state_q == ST_WAIT) || (state_q == ST_LOCKED)) &&
                 ((state_d == ST_WAIT) || (state_d == ST_LOCKED));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
         cfg_rdy_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
         cfg_rdy_q  <= cfg_rdy_d;
      end
   end

   assign locked  = locked_q;
   assign cfg_rdy = cfg_rdy_q;

`ifdef CLKDIV_READBACK_EN
   logic [NUM_CH-1:0][3*DIV_W-1:0] lane_cfg;
   logic [3*DIV_W-1:0]             rd_mux, cfg_do_q, cfg_do_d;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      clk_div_lane #(
         .DIV_W       (DIV_W),
         .DIV_DEFAULT (DIV_DEFAULT)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (lane_wr[g]),
         .wr_data (cfg_di),
         .load    (load),
         .run     (run),
         .clk_out (clk_out[g]),
         .tick    (tick[g])
`ifdef CLKDIV_READBACK_EN
         ,
         .cfg_raw (lane_cfg[g])
`endif
      );
   end

`ifdef CLKDIV_READBACK_EN
   // Unmatched (out-of-range) addresses fall through to zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (cfg_addr == ADDR_W'(i))
            rd_mux = lane_cfg[i];
      cfg_do_d = (cfg_en && !cfg_we) ? rd_mux : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cfg_do_q <= '0;
      else
         cfg_do_q <= cfg_do_d;
   end

   assign cfg_do = cfg_do_q;
`else
   assign cfg_do = '0;
`endif

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: driver pushes model expectations per edge, monitor pops and compares.
module tb_clk_div_bank;
   localparam int NUM_CH = 6, DIV_W = 8, ADDR_W = 4, DIV_DEFAULT = 2, LOCK_CYCLES = 64;
   localparam int CW = 3 * DIV_W;

   logic              clk = 1'b0, rst_n = 1'b1, pwrdwn = 1'b0, cfg_en = 1'b0, cfg_we = 1'b0;
   logic [ADDR_W-1:0] cfg_addr = '0;
   logic [CW-1:0]     cfg_di = '0;
   logic [CW-1:0]     cfg_do;
   logic              cfg_rdy, locked;
   logic [NUM_CH-1:0] clk_out, tick;

   typedef struct packed {
      logic [NUM_CH-1:0] clk_out;
      logic [NUM_CH-1:0] tick;
      logic              locked;
      logic              rdy;
      logic              chk_do;
      logic [CW-1:0]     dout;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0, bad = 0;
   int   m_div[NUM_CH], m_hi[NUM_CH], m_ph[NUM_CH];
   int   age;   // edges since the last alignment edge; -1 = next edge aligns, -2 = idle

   clk_div_bank #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .ADDR_W(ADDR_W),
      .DIV_DEFAULT(DIV_DEFAULT), .LOCK_CYCLES(LOCK_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pwrdwn(pwrdwn), .cfg_en(cfg_en), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_di(cfg_di), .cfg_do(cfg_do), .cfg_rdy(cfg_rdy),
      .clk_out(clk_out), .tick(tick), .locked(locked)
   );

   always #5 clk = ~clk;

   function automatic void check(string nm, logic [63:0] act, logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, expv, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_div[i] = DIV_DEFAULT;
         m_hi[i]  = DIV_DEFAULT / 2;
         m_ph[i]  = 0;
      end
      age = -2;
   endfunction

   // Waveform position is (P + edges since align) mod D; lock after LOCK_CYCLES edges of stability.
   function automatic exp_t model_edge(bit pwr, bit en, bit we, int addr, logic [CW-1:0] di);
      exp_t e;
      bit   wr_ok, realign;
      int   d, h, p, pos, nage;
      e       = '0;
      wr_ok   = en && we && (addr < NUM_CH);
      realign = wr_ok && (age >= -1);
      if (!pwr && !realign && age >= 0)
         for (int i = 0; i < NUM_CH; i++) begin
            d   = (m_div[i] < 2) ? 2 : m_div[i];
            h   = (m_hi[i] < 1) ? 1 : ((m_hi[i] > d - 1) ? d - 1 : m_hi[i]);
            p   = (m_ph[i] < d) ? m_ph[i] : 0;
            pos = (p + age) % d;
            e.clk_out[i] = (pos < h);
            e.tick[i]    = (pos == 0);
         end
      nage     = pwr ? -2 : (realign ? -1 : age + 1);
      e.locked = (nage >= LOCK_CYCLES);
      e.rdy    = en;
      e.chk_do = en && !we;
`ifdef CLKDIV_READBACK_EN
      if (en && !we && addr < NUM_CH)
         e.dout = {DIV_W'(m_ph[addr]), DIV_W'(m_hi[addr]), DIV_W'(m_div[addr])};
`endif
      if (wr_ok) begin
         m_div[addr] = int'(di[DIV_W-1:0]);
         m_hi[addr]  = int'(di[2*DIV_W-1:DIV_W]);
         m_ph[addr]  = int'(di[CW-1:2*DIV_W]);
      end
      age = nage;
      return e;
   endfunction

   task automatic drive(bit pwr, bit en, bit we, int addr, int dv, int hv, int pv);
      logic [CW-1:0] di;
      di = {DIV_W'(pv), DIV_W'(hv), DIV_W'(dv)};
      @(negedge clk); #1;
      rst_n = 1'b1; pwrdwn = pwr; cfg_en = en; cfg_we = we;
      cfg_addr = ADDR_W'(addr); cfg_di = di;
      exp_q.push_back(model_edge(pwr, en, we, addr, di));
   endtask

   task automatic idle(int n);
      repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(int a, int p, int h, int d);
      drive(0, 1, 1, a, d, h, p);
   endtask

   task automatic rd(int a);
      drive(0, 1, 0, a, 0, 0, 0);
   endtask

   task automatic hold_reset(int n);
      repeat (n) begin
         @(negedge clk); #1;
         rst_n = 1'b0; pwrdwn = 1'b0; cfg_en = 1'b0;
         model_reset();
         exp_q.push_back('0);
      end
   endtask

   // Reset asserted between edges: outputs must clear before any clock arrives.
   task automatic async_reset();
      @(negedge clk); #3;
      rst_n = 1'b0; pwrdwn = 1'b0; cfg_en = 1'b0;
      #1;
      check("async_clk_out", 64'(clk_out), 64'd0);
      check("async_tick", 64'(tick), 64'd0);
      check("async_locked", 64'(locked), 64'd0);
      check("async_rdy", 64'(cfg_rdy), 64'd0);
      model_reset();
      exp_q.push_back('0);
   endtask

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("clk_out", 64'(clk_out), 64'(e.clk_out));
         check("tick", 64'(tick), 64'(e.tick));
         check("locked", 64'(locked), 64'(e.locked));
         check("cfg_rdy", 64'(cfg_rdy), 64'(e.rdy));
         if (e.chk_do) check("cfg_do", 64'(cfg_do), 64'(e.dout));
      end
   end

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      hold_reset(3);
      idle(70);                              // default lock and 1010 pattern
      wr(1, 0, 2, 5); idle(70);              // ch1 div 5, hi 2
      wr(0, 0, 2, 4); wr(2, 1, 2, 4); idle(70);
      wr(4, 9, 0, 0); wr(5, 0, 7, 4); idle(70);
      wr(9, 1, 1, 1); idle(5);               // out of range: no realign
      wr(3, 0, 1, 3); idle(20);
      repeat (10) drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 2, 6, 2, 1);            // write with pwrdwn on the same edge
      idle(70);
      wr(3, 3, 4, 9); rd(3); rd(15); rd(0); idle(5);
      idle(70);
      async_reset();
      idle(70);
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 5))
            0, 1: wr($urandom_range(0, NUM_CH - 1), $urandom_range(0, 11),
                     $urandom_range(0, 11), $urandom_range(0, 11));
            2: wr($urandom_range(0, 15), $urandom_range(0, 11),
                  $urandom_range(0, 11), $urandom_range(0, 11));
            3: rd($urandom_range(0, 15));
            4: repeat ($urandom_range(1, 12)) drive(1, 0, 0, 0, 0, 0, 0);
            default: begin
               wr($urandom_range(0, NUM_CH - 1), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7));
               rd($urandom_range(0, 15));
               rd($urandom_range(0, NUM_CH - 1));
            end
         endcase
         idle($urandom_range(1, 90));
      end
      idle(3);
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
